// File: rtl/dut_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dut_port_arbiter
//  Purpose  : Two-requester arbiter/sequencer in front of the 8x1 dut storage
//             block. Accepts one read or write at a time, drives the dut
//             write_*/read_* method ports under their ready/enable rules and
//             returns a one-cycle response (read data or timeout error).
//  Ports    : CLK, RST_N (async, active-low)
//             reqN_valid/write/addr/wdata -> reqN_ready     (requester side)
//             rspN_valid/data/err                           (response side)
//             write_address/data/en <- write_rdy            (dut write port)
//             read_address/en, read_data <- read_rdy        (dut read port)
//             busy                                          (FSM not IDLE)
//  Config   : ARB_FIXED_PRIORITY_EN - requester 0 always wins a tie; the
//             round-robin pointer is removed.
//  Revision : 1.0 - initial release
// ============================================================================
module dut_port_arbiter #(
    parameter int unsigned TIMEOUT = 15     // legal range 1..255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic [2:0] req0_addr,
    input  logic       req0_wdata,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic [2:0] req1_addr,
    input  logic       req1_wdata,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic       rsp0_data,
    output logic       rsp0_err,
    output logic       rsp1_valid,
    output logic       rsp1_data,
    output logic       rsp1_err,
    output logic [2:0] write_address,
    output logic       write_data,
    output logic       write_en,
    input  logic       write_rdy,
    output logic [2:0] read_address,
    output logic       read_en,
    input  logic       read_data,
    input  logic       read_rdy,
    output logic       busy
);

    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_grant;
    logic       r_write;
    logic [2:0] r_addr;
    logic       r_wdata;
    logic [7:0] r_wait_cnt;
    logic       r_rsp_data;
    logic       r_rsp_err;
`ifndef ARB_FIXED_PRIORITY_EN
    logic       r_ptr;
`endif

    logic w_any_req;
    logic w_winner;
    logic w_accept;
    logic w_issue;
    logic w_issue_wr;
    logic w_issue_rd;
    logic w_fire;
    logic w_timeout;

    assign w_any_req = req0_valid | req1_valid;

`ifdef ARB_FIXED_PRIORITY_EN
    // Requester 1 only wins when requester 0 is idle.
    assign w_winner = ~req0_valid;
`else
    // Tie goes to the pointer; otherwise the sole requester wins.
    assign w_winner = (req0_valid & req1_valid) ? r_ptr : req1_valid;
`endif

    // Reset gating keeps every output low while RST_N is asserted, even with
    // requests or readies already high.
    assign w_accept   = RST_N & (r_state == S_IDLE) & w_any_req;
    assign w_issue    = RST_N & (r_state == S_ISSUE);
    assign w_issue_wr = w_issue & r_write;
    assign w_issue_rd = w_issue & ~r_write;

    assign req0_ready = w_accept & ~w_winner;
    assign req1_ready = w_accept &  w_winner;

    // Enables follow the matching ready combinationally; r_write makes them
    // mutually exclusive.
    assign write_en      = w_issue_wr & write_rdy;
    assign read_en       = w_issue_rd & read_rdy;
    assign write_address = w_issue_wr ? r_addr : 3'd0;
    assign write_data    = w_issue_wr & r_wdata;
    assign read_address  = w_issue_rd ? r_addr : 3'd0;

    assign w_fire    = write_en | read_en;
    // Fire wins over timeout in the last allowed wait cycle.
    assign w_timeout = ~w_fire & (r_wait_cnt == C_WAIT_LAST);

    // Response outputs decode straight from registered state.
    assign rsp0_valid = (r_state == S_RESP) & ~r_grant;
    assign rsp1_valid = (r_state == S_RESP) &  r_grant;
    assign rsp0_data  = rsp0_valid & r_rsp_data;
    assign rsp0_err   = rsp0_valid & r_rsp_err;
    assign rsp1_data  = rsp1_valid & r_rsp_data;
    assign rsp1_err   = rsp1_valid & r_rsp_err;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= 3'd0;
            r_wdata    <= 1'b0;
            r_wait_cnt <= 8'd0;
            r_rsp_data <= 1'b0;
            r_rsp_err  <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
            r_ptr      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant    <= w_winner;
                        r_write    <= w_winner ? req1_write : req0_write;
                        r_addr     <= w_winner ? req1_addr  : req0_addr;
                        r_wdata    <= w_winner ? req1_wdata : req0_wdata;
                        r_wait_cnt <= 8'd0;
                        r_rsp_data <= 1'b0;
                        r_rsp_err  <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
                        r_ptr      <= ~w_winner;
`endif
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_fire) begin
                        // read_en is low on a write fire, so writes return 0.
                        r_rsp_data <= read_en & read_data;
                        r_rsp_err  <= 1'b0;
                        r_state    <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp_data <= 1'b0;
                        r_rsp_err  <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dut_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dut_port_arbiter
//  Purpose  : Self-checking bench for dut_port_arbiter. A tiny 8x1 memory
//             stands in for the dut storage block.
//  Config   : honours ARB_FIXED_PRIORITY_EN for the tie-break expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dut_port_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       req0_valid, req0_write, req0_wdata, req0_ready;
    logic [2:0] req0_addr;
    logic       req1_valid, req1_write, req1_wdata, req1_ready;
    logic [2:0] req1_addr;
    logic       rsp0_valid, rsp0_data, rsp0_err;
    logic       rsp1_valid, rsp1_data, rsp1_err;
    logic [2:0] write_address, read_address;
    logic       write_data, write_en, write_rdy;
    logic       read_en, read_data, read_rdy;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem = 8'h00;

    dut_port_arbiter #(.TIMEOUT(15)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .write_address(write_address), .write_data(write_data),
        .write_en(write_en), .write_rdy(write_rdy),
        .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Storage model
    always @(posedge CLK) if (write_en) mem[write_address] <= write_data;
    assign read_data = mem[read_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- invariants and random-phase scoreboard ----------------
    bit         sb_en = 1'b0;
    bit         sb_inflight = 1'b0;
    bit         sb_req, sb_wr, sb_en_seen;
    logic [2:0] sb_addr;
    int         sb_age;

    always @(negedge CLK) begin
        check("inv_excl",    32'(write_en & read_en), 0);
        check("inv_wen_rdy", 32'(write_en & ~write_rdy), 0);
        check("inv_ren_rdy", 32'(read_en & ~read_rdy), 0);
        check("inv_en_busy", 32'((write_en | read_en) & ~busy), 0);
        if (sb_en) begin
            if (write_en | read_en) sb_en_seen = 1'b1;
            if (rsp0_valid | rsp1_valid) begin
                check("sb_rsp_expected", 32'(sb_inflight), 1);
                check("sb_rsp_port", {30'd0, rsp1_valid, rsp0_valid}, sb_req ? 32'd2 : 32'd1);
                check("sb_rsp_err", 32'(rsp0_err | rsp1_err), 32'(!sb_en_seen));
                check("sb_rsp_data", 32'(rsp0_data | rsp1_data),
                      32'((sb_en_seen && !sb_wr) ? mem[sb_addr] : 1'b0));
                sb_inflight = 1'b0;
            end
            if (sb_inflight) begin
                sb_age++;
                check("sb_age", 32'(sb_age > 17), 0);
            end
            if (req0_ready | req1_ready) begin
                check("sb_accept_idle", 32'(sb_inflight), 0);
                check("sb_one_ready", 32'(req0_ready & req1_ready), 0);
                sb_inflight = 1'b1;
                sb_req      = req1_ready;
                sb_wr       = req1_ready ? req1_write : req0_write;
                sb_addr     = req1_ready ? req1_addr : req0_addr;
                sb_en_seen  = 1'b0;
                sb_age      = 0;
            end
        end
    end

    // ---------------- directed transaction helper ----------------
    task automatic set_req(input int req, input logic v, input logic wr,
                           input logic [2:0] a, input logic d);
        if (req == 0) begin
            req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic run_txn(input string tag, input int req, input logic wr,
                           input logic [2:0] a, input logic d, input int stall,
                           input int exp_lat, input logic exp_data,
                           input logic exp_err, input logic exp_en);
        int lat = 0;
        bit got = 0, en_seen = 0, en_wr = 0, en_wd = 0, g_data = 0, g_err = 0;
        int en_lat = -1;
        logic [2:0] en_addr = 3'd0;
        logic [1:0] g_port = 2'd0;
        @(posedge CLK); #1;
        set_req(req, 1'b1, wr, a, d);
        if (wr) write_rdy = (stall == 0); else read_rdy = (stall == 0);
        @(negedge CLK);
        check({tag, "_accept"}, 32'(req ? req1_ready : req0_ready), 1);
        check({tag, "_other_ready"}, 32'(req ? req0_ready : req1_ready), 0);
        while (!got && lat < 40) begin
            @(posedge CLK); #1;
            set_req(req, 1'b0, wr, a, d);
            lat++;
            if (wr) write_rdy = (lat > stall); else read_rdy = (lat > stall);
            @(negedge CLK);
            if ((write_en | read_en) && !en_seen) begin
                en_seen = 1; en_lat = lat; en_wr = write_en;
                en_addr = write_en ? write_address : read_address;
                en_wd   = write_data;
            end
            if (rsp0_valid | rsp1_valid) begin
                got = 1; g_port = {rsp1_valid, rsp0_valid};
                g_data = req ? rsp1_data : rsp0_data;
                g_err  = req ? rsp1_err  : rsp0_err;
            end
        end
        check({tag, "_rsp_seen"}, 32'(got), 1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_rsp_port"}, 32'(g_port), req ? 32'd2 : 32'd1);
        check({tag, "_rsp_data"}, 32'(g_data), 32'(exp_data));
        check({tag, "_rsp_err"}, 32'(g_err), 32'(exp_err));
        check({tag, "_en_seen"}, 32'(en_seen), 32'(exp_en));
        if (exp_en) begin
            check({tag, "_en_cycle"}, en_lat, exp_lat - 1);
            check({tag, "_en_addr"}, 32'(en_addr), 32'(a));
            check({tag, "_en_kind"}, 32'(en_wr), 32'(wr));
            if (wr) check({tag, "_en_wdata"}, 32'(en_wd), 32'(d));
        end
        write_rdy = 1'b1;
        read_rdy  = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit acc0 = 0, acc1 = 0;
        int w;
        int exp_g;
        req0_write = 0; req0_addr = 0; req0_wdata = 0;
        req1_write = 0; req1_addr = 0; req1_wdata = 0;
        req0_valid = 1; req1_valid = 1;
        write_rdy = 1; read_rdy = 1;

        // Reset: every output low despite requests and readies high
        @(negedge CLK);
        check("rst_req0_ready", 32'(req0_ready), 0);
        check("rst_req1_ready", 32'(req1_ready), 0);
        check("rst_write_en", 32'(write_en), 0);
        check("rst_read_en", 32'(read_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 0);
        check("rst_addr", 32'({write_address, read_address}), 0);
        @(posedge CLK); #1;
        req0_valid = 0; req1_valid = 0; RST_N = 1;

        // Tie straight after reset: pointer is 0, requester 0 wins
        @(posedge CLK); #1;
        set_req(0, 1'b1, 1'b0, 3'd0, 1'b0);
        set_req(1, 1'b1, 1'b0, 3'd1, 1'b0);
        @(negedge CLK);
        check("tie0_req0_ready", 32'(req0_ready), 1);
        check("tie0_req1_ready", 32'(req1_ready), 0);
        @(posedge CLK); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (3) @(posedge CLK);

        run_txn("wr5",      0, 1'b1, 3'd5, 1'b1, 0,    2,  1'b0, 1'b0, 1'b1);
        run_txn("rd5",      0, 1'b0, 3'd5, 1'b0, 0,    2,  1'b1, 1'b0, 1'b1);
        run_txn("rd_stall", 0, 1'b0, 3'd5, 1'b0, 4,    6,  1'b1, 1'b0, 1'b1);
        run_txn("wr_tmo",   1, 1'b1, 3'd2, 1'b1, 1000, 16, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge CLK);

        // Both requesters hold valid for six accepts (pointer is 0 here)
        @(posedge CLK); #1;
        set_req(0, 1'b1, 1'b0, 3'd5, 1'b0);
        set_req(1, 1'b1, 1'b0, 3'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            w = 0;
            @(negedge CLK);
            while (!(req0_ready | req1_ready) && w < 10) begin
                @(negedge CLK);
                w++;
            end
`ifdef ARB_FIXED_PRIORITY_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            check("both_seen", 32'(req0_ready | req1_ready), 1);
            check("both_grant", 32'(req1_ready), exp_g);
            check("both_gap", w, (i == 0) ? 0 : 2);
        end
        @(posedge CLK); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (3) @(posedge CLK);

        // Reset pulse during the ISSUE cycle of a read
        @(posedge CLK); #1;
        set_req(0, 1'b1, 1'b0, 3'd5, 1'b0);
        @(negedge CLK);
        check("mid_accept", 32'(req0_ready), 1);
        @(posedge CLK); #1;
        req0_valid = 0;
        #1;
        check("mid_pre_read_en", 32'(read_en), 1);
        RST_N = 0;
        set_req(1, 1'b1, 1'b0, 3'd3, 1'b0);
        #1;
        check("mid_busy", 32'(busy), 0);
        check("mid_read_en", 32'(read_en), 0);
        check("mid_read_addr", 32'(read_address), 0);
        check("mid_req1_ready", 32'(req1_ready), 0);
        @(negedge CLK);
        @(negedge CLK);
        check("mid_no_rsp", 32'(rsp0_valid | rsp1_valid), 0);
        @(posedge CLK); #1;
        RST_N = 1;
        @(negedge CLK);
        check("mid_req1_alone", 32'(req1_ready), 1);
        check("mid_req0_not", 32'(req0_ready), 0);
        @(posedge CLK); #1;
        req1_valid = 0;
        @(negedge CLK);
        @(negedge CLK);
        check("mid_rsp1_valid", 32'(rsp1_valid), 1);
        check("mid_rsp1_data", 32'(rsp1_data), 0);
        check("mid_rsp0_quiet", 32'(rsp0_valid), 0);
        repeat (2) @(posedge CLK);

        // Random requests with random ready stalls
        sb_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge CLK); #1;
            write_rdy = ($urandom_range(0, 3) != 0);
            read_rdy  = ($urandom_range(0, 3) != 0);
            if (!req0_valid || acc0) begin
                if ($urandom_range(0, 2) == 0)
                    set_req(0, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                            1'($urandom_range(0, 1)));
                else
                    req0_valid = 0;
            end
            if (!req1_valid || acc1) begin
                if ($urandom_range(0, 2) == 0)
                    set_req(1, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                            1'($urandom_range(0, 1)));
                else
                    req1_valid = 0;
            end
            @(negedge CLK);
            acc0 = req0_ready;
            acc1 = req1_ready;
        end
        @(posedge CLK); #1;
        req0_valid = 0; req1_valid = 0; write_rdy = 1; read_rdy = 1;
        repeat (20) @(negedge CLK);
        check("sb_drain", 32'(sb_inflight), 0);
        sb_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
